// File: rtl/fx_kport_pad.sv
// PC-FX K-port joypad responder: latches {PAD_ID, 14'h0, BTN} on the host trigger and shifts it out LSB first.
// Optional turbo on buttons I/II is enabled by defining FX_PAD_TURBO_EN (adds the BTN_TURBO port).
module fx_kport_pad #(
  parameter logic [3:0] PAD_ID      = 4'hF,
  parameter int         TIMEOUT     = 4096,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic        KP_TRGn,
  input  logic        KP_SCK,
  output logic        KP_SO,
  input  logic        CONNECTED,
  input  logic [13:0] BTN,
`ifdef FX_PAD_TURBO_EN
  input  logic [1:0]  BTN_TURBO,
`endif
  output logic        BUSY,
  output logic [5:0]  BIT_CNT
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] trg_sync_p0, sck_sync_p0;
  logic                   trg_prev_p1, sck_prev_p1;
  logic                   trg_fall_p2, trg_rise_p2, sck_rise_p2;

  logic [31:0]     shift_q;
  logic [5:0]      bit_cnt_q;
  logic [TO_W-1:0] to_cnt_q;

  logic [13:0] btn_eff;
  logic [31:0] load_word;
  logic        load, shift_en, tmo_hit, to_clr, to_inc;

  // Stage p0: synchronizers, p1: previous level, p2: registered one-CE-cycle edge strobes
  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      trg_sync_p0 <= '1;
      sck_sync_p0 <= '1;
      trg_prev_p1 <= 1'b1;
      sck_prev_p1 <= 1'b1;
      trg_fall_p2 <= 1'b0;
      trg_rise_p2 <= 1'b0;
      sck_rise_p2 <= 1'b0;
    end else if (CE) begin
      trg_sync_p0 <= {trg_sync_p0[SYNC_STAGES-2:0], KP_TRGn};
      sck_sync_p0 <= {sck_sync_p0[SYNC_STAGES-2:0], KP_SCK};
      trg_prev_p1 <= trg_sync_p0[SYNC_STAGES-1];
      sck_prev_p1 <= sck_sync_p0[SYNC_STAGES-1];
      trg_fall_p2 <= trg_prev_p1 & ~trg_sync_p0[SYNC_STAGES-1];
      trg_rise_p2 <= ~trg_prev_p1 & trg_sync_p0[SYNC_STAGES-1];
      sck_rise_p2 <= ~sck_prev_p1 & sck_sync_p0[SYNC_STAGES-1];
    end
  end

`ifdef FX_PAD_TURBO_EN
  logic phase_q;

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) phase_q <= 1'b0;
    else if (load) phase_q <= ~phase_q;
  end
`endif

  always_comb begin
    btn_eff = BTN;
`ifdef FX_PAD_TURBO_EN
    // The word uses the phase value the flop toggles to on this load, so the first load after reset passes the button
    btn_eff[1:0] = BTN[1:0] & (~BTN_TURBO | {2{~phase_q}});
`endif
    load_word = CONNECTED ? {PAD_ID, 14'h0, btn_eff} : 32'h0;
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    tmo_hit  = 1'b0;
    to_clr   = 1'b0;
    to_inc   = 1'b0;
    if (CE) begin
      case (state_q)
        ST_IDLE: begin
          if (trg_fall_p2) begin
            load    = 1'b1;
            state_d = ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (trg_rise_p2) begin
            to_clr  = 1'b1;
            state_d = ST_SHIFT;
          end else if (to_cnt_q == TO_LAST) begin
            tmo_hit = 1'b1;
            state_d = ST_IDLE;
          end else begin
            to_inc = 1'b1;
          end
        end
        ST_SHIFT: begin
          // A new trigger restarts the transfer and wins over a coincident SCK edge
          if (trg_fall_p2) begin
            load    = 1'b1;
            state_d = ST_LATCH;
          end else if (sck_rise_p2) begin
            shift_en = 1'b1;
            if (bit_cnt_q == 6'd31) state_d = ST_IDLE;
          end else if (to_cnt_q == TO_LAST) begin
            tmo_hit = 1'b1;
            state_d = ST_IDLE;
          end else begin
            to_inc = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      shift_q   <= 32'h0;
      bit_cnt_q <= 6'd0;
      to_cnt_q  <= '0;
    end else if (load) begin
      shift_q   <= load_word;
      bit_cnt_q <= 6'd0;
      to_cnt_q  <= '0;
    end else if (shift_en) begin
      // Ones fill from the top so the line idles high once the word is exhausted
      shift_q   <= {1'b1, shift_q[31:1]};
      bit_cnt_q <= bit_cnt_q + 6'd1;
      to_cnt_q  <= '0;
    end else if (tmo_hit) begin
      bit_cnt_q <= 6'd0;
      to_cnt_q  <= '0;
    end else if (to_clr) begin
      to_cnt_q  <= '0;
    end else if (to_inc) begin
      to_cnt_q  <= to_cnt_q + TO_W'(1);
    end
  end

  always_comb begin
    BUSY    = (state_q != ST_IDLE);
    KP_SO   = (state_q == ST_IDLE) ? 1'b1 : shift_q[0];
    BIT_CNT = bit_cnt_q;
  end

endmodule

// File: tb/tb_fx_kport_pad.sv
// Bench for fx_kport_pad: a host model drives trigger/serial-clock transfers with random CE and button data,
// and received words are checked against a word model built from the pad's word-format rules.
module tb_fx_kport_pad;

  localparam int TMO  = 16;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic        CLK = 1'b0;
  logic        RESn = 1'b0;
  logic        CE = 1'b1;
  logic        KP_TRGn = 1'b1;
  logic        KP_SCK = 1'b0;
  logic        CONNECTED = 1'b1;
  logic [13:0] BTN = 14'h0;
`ifdef FX_PAD_TURBO_EN
  logic [1:0]  BTN_TURBO = 2'b00;
  bit          tb_phase = 1'b0;
`endif
  logic        KP_SO;
  logic        BUSY;
  logic [5:0]  BIT_CNT;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_on = 1'b0;
  bit          track = 1'b0;
  logic [31:0] exp_w = 32'h0;
  logic [31:0] rx = 32'h0;

  fx_kport_pad #(.PAD_ID(4'hF), .TIMEOUT(TMO), .SYNC_STAGES(SYNC)) dut (
    .CLK(CLK),
    .RESn(RESn),
    .CE(CE),
    .KP_TRGn(KP_TRGn),
    .KP_SCK(KP_SCK),
    .KP_SO(KP_SO),
    .CONNECTED(CONNECTED),
    .BTN(BTN),
`ifdef FX_PAD_TURBO_EN
    .BTN_TURBO(BTN_TURBO),
`endif
    .BUSY(BUSY),
    .BIT_CNT(BIT_CNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) CE = ($urandom_range(0, 3) != 0);

  initial begin
    repeat (95000) @(posedge CLK);
    $display("FAIL watchdog: got no end of test, want finish before 95000 cycles");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] model_word(input logic [13:0] b, input logic c);
    logic [13:0] e;
    e = b;
`ifdef FX_PAD_TURBO_EN
    e[1:0] = b[1:0] & (~BTN_TURBO | {2{tb_phase}});
`endif
    return c ? {4'hF, 14'h0, e} : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Per-cycle compare: idle line is high, and while busy the line carries the word bit at the current count
  always @(negedge CLK) begin
    if (chk_on && RESn) begin
      n_cmp++;
      if (BIT_CNT > 6'd32 || (!BUSY && KP_SO !== 1'b1)) begin
        n_bad++;
        $display("FAIL idle_line: got so=%b busy=%b cnt=%0d want so=1 when idle, cnt<=32", KP_SO, BUSY, BIT_CNT);
      end
      if (track && BUSY && BIT_CNT < 6'd32) begin
        n_cmp++;
        if (KP_SO !== exp_w[BIT_CNT[4:0]]) begin
          n_bad++;
          $display("FAIL so_stream: got %b want %b at bit %0d", KP_SO, exp_w[BIT_CNT[4:0]], BIT_CNT);
        end
      end
    end
  end

  task automatic ce_wait(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge CLK);
      if (CE) k++;
    end
    @(negedge CLK);
  endtask

  task automatic start_xfer();
    track   = 1'b0;
    KP_TRGn = 1'b0;
`ifdef FX_PAD_TURBO_EN
    tb_phase = ~tb_phase;
`endif
    exp_w = model_word(BTN, CONNECTED);
    ce_wait(6);
    check("latch_busy", 32'(BUSY), 32'd1);
    check("latch_cnt", 32'(BIT_CNT), 32'd0);
    KP_TRGn = 1'b1;
    ce_wait(6);
    check("shift_busy", 32'(BUSY), 32'd1);
    track = 1'b1;
  endtask

  task automatic clock_bits(input int first, input int n, input int h);
    for (int i = first; i < first + n; i++) begin
      check("bit_value", 32'(KP_SO), 32'(exp_w[i]));
      check("bit_cnt_pre", 32'(BIT_CNT), i);
      rx[i]  = KP_SO;
      KP_SCK = 1'b1;
      ce_wait(LAT - 1);
      check("bit_cnt_hold", 32'(BIT_CNT), i);
      ce_wait(1);
      check("bit_cnt_step", 32'(BIT_CNT), i + 1);
      ce_wait(h - LAT);
      KP_SCK = 1'b0;
      ce_wait(h);
    end
  endtask

  task automatic finish_check();
    check("end_busy", 32'(BUSY), 32'd0);
    check("end_cnt", 32'(BIT_CNT), 32'd32);
    check("end_so", 32'(KP_SO), 32'd1);
    track = 1'b0;
  endtask

  task automatic full_read(input int h, input logic [31:0] want, input string name);
    start_xfer();
    check({name, "_model"}, exp_w, want);
    clock_bits(0, 32, h);
    finish_check();
    check(name, rx, want);
  endtask

  task automatic do_reset_release();
    @(negedge CLK);
    RESn = 1'b1;
    ce_wait(4);
    chk_on = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check("rst_so", 32'(KP_SO), 32'd1);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_cnt", 32'(BIT_CNT), 32'd0);
    do_reset_release();

    check("model_pin_0081", model_word(14'h0081, 1'b1), 32'hF000_0081);
    check("model_pin_3fff", model_word(14'h3FFF, 1'b1), 32'hF000_3FFF);
    check("model_pin_disc", model_word(14'h3FFF, 1'b0), 32'h0000_0000);

    BTN = 14'h0081;
    CONNECTED = 1'b1;
    full_read(5, 32'hF000_0081, "read_0081");

    BTN = 14'h3FFF;
    CONNECTED = 1'b0;
    full_read(6, 32'h0000_0000, "read_disc");

    // Stall after five bits: the 16th CE cycle without an SCK edge drops back to idle
    BTN = 14'h0081;
    CONNECTED = 1'b1;
    start_xfer();
    clock_bits(0, 5, 5);
    check("tmo_busy_early", 32'(BUSY), 32'd1);
    check("tmo_cnt_early", 32'(BIT_CNT), 32'd5);
    ce_wait(9);
    check("tmo_busy_15", 32'(BUSY), 32'd1);
    ce_wait(1);
    track = 1'b0;
    check("tmo_busy_16", 32'(BUSY), 32'd0);
    check("tmo_cnt_16", 32'(BIT_CNT), 32'd0);
    check("tmo_so_16", 32'(KP_SO), 32'd1);
    full_read(5, 32'hF000_0081, "read_after_tmo");

    // Restart after ten bits, then change buttons mid-transfer
    BTN = 14'h1234;
    start_xfer();
    clock_bits(0, 10, 6);
    BTN = 14'h0081;
    start_xfer();
    BTN = 14'h0000;
    CONNECTED = 1'b0;
    clock_bits(0, 32, 5);
    finish_check();
    check("restart_word", rx, 32'hF000_0081);
    CONNECTED = 1'b1;

    // Asynchronous reset in the middle of a transfer
    BTN = 14'h2AAA;
    start_xfer();
    clock_bits(0, 3, 5);
    chk_on = 1'b0;
    track  = 1'b0;
    @(negedge CLK);
    #2 RESn = 1'b0;
    #1;
    check("midrst_so", 32'(KP_SO), 32'd1);
    check("midrst_busy", 32'(BUSY), 32'd0);
    check("midrst_cnt", 32'(BIT_CNT), 32'd0);
`ifdef FX_PAD_TURBO_EN
    tb_phase = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    do_reset_release();

    BTN = 14'h0001;
`ifdef FX_PAD_TURBO_EN
    BTN_TURBO = 2'b01;
`endif
    for (int k = 0; k < 4; k++) begin
      logic [31:0] want;
      want = 32'hF000_0001;
`ifdef FX_PAD_TURBO_EN
      want[0] = (k % 2 == 0);
`endif
      full_read(5, want, "turbo_read");
    end
`ifdef FX_PAD_TURBO_EN
    BTN_TURBO = 2'b00;
`endif

    BTN = 14'h0081;
    full_read(7, 32'hF000_0081, "read_after_rst");

    for (int r = 0; r < 16; r++) begin
      int h;
      h = $urandom_range(5, 7);
      BTN = 14'($urandom);
      CONNECTED = ($urandom_range(0, 3) != 0);
      start_xfer();
      clock_bits(0, 16, h);
      BTN = 14'($urandom);
      CONNECTED = 1'($urandom_range(0, 1));
      clock_bits(16, 16, h);
      finish_check();
      check("rand_word", rx, exp_w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fx_kport_pad.md
Name: fx_kport_pad

Overview:
- Device end of the PC-FX K-port: a joypad responder that answers the gate array's keypad transfer.
- On trigger, it latches 14 button states plus a device ID into a 32-bit word.
- It then shifts the word out serially, LSB first, on the host-driven serial clock.
- It sits between the MiSTer input framework (button vector) and the gate array K-port pins; one instance per port.

Parameters:
PAD_ID, 4'hF, device ID placed in word bits [31:28] (4'hF = standard pad)
TIMEOUT, 4096, CE cycles without an SCK rising edge before an in-progress transfer aborts to IDLE
SYNC_STAGES, 2, flip-flop stages on each asynchronous K-port input (minimum 2)

Ports:
CLK  in  1  system clock
RESn  in  1  asynchronous active-low reset
CE  in  1  clock enable; all sequential logic advances only when CE=1
KP_TRGn  in  1  K-port trigger/latch from host, active-low, asynchronous to CLK
KP_SCK  in  1  K-port serial clock from host, asynchronous to CLK
KP_SO  out  1  K-port serial data to host
CONNECTED  in  1  1 = pad present
BTN  in  14  active-high buttons: [5:0]=I..VI, [6]=Select, [7]=Run, [8]=Up, [9]=Right, [10]=Down, [11]=Left, [12]=Mode1, [13]=Mode2
BUSY  out  1  1 while in LATCH or SHIFT
BIT_CNT  out  6  bits shifted in the current transfer, 0..32

Behaviour:
- Reset (RESn=0, asynchronous):
  - state=IDLE, shift register=0, BIT_CNT=0, timeout counter=0.
  - KP_SO=1, BUSY=0; synchronizer flops set to 1.
- Input handling:
  - KP_TRGn and KP_SCK each pass through SYNC_STAGES flops, then a one-flop edge detector.
  - Edges are detected on CE cycles only.
- Word format: {PAD_ID, 14'h0, BTN} when CONNECTED=1; 32'h0 when CONNECTED=0.
- States:
  - IDLE:
    - KP_SO=1.
    - On TRGn falling edge: load word into shift register, BIT_CNT=0, go to LATCH.
  - LATCH:
    - KP_SO = shift[0].
    - Stays while TRGn low.
    - TRGn rising edge -> SHIFT.
    - An SCK rising edge while in LATCH is ignored.
  - SHIFT:
    - KP_SO = shift[0].
    - On each SCK rising edge: shift right by one with 1 filled at MSB, BIT_CNT+1, timeout counter cleared.
    - When BIT_CNT reaches 32 -> IDLE; KP_SO is then 1 since all fill bits are 1.
- Latency: KP_SO reflects a new bit SYNC_STAGES+2 CE cycles after the asynchronous SCK rising edge. The host must hold SCK phases at least SYNC_STAGES+3 CE cycles.
- Timeout:
  - In LATCH or SHIFT, the counter increments each CE cycle with no qualifying edge.
  - At TIMEOUT-1 -> IDLE, BIT_CNT=0, KP_SO=1.
- Simultaneous events:
  - A TRGn falling edge in SHIFT restarts the transfer: reload the word, BIT_CNT=0, go to LATCH. This takes priority over an SCK edge in the same cycle.
  - TRGn falling and rising edges cannot coincide because there is a single synchronized signal.
- BTN sampling: BTN is sampled only at the load cycle; later BTN changes do not affect an in-progress transfer.
- CONNECTED=0 mid-transfer: no effect until the next load.
- BUSY = (state != IDLE).
- Reset mid-transfer: immediate return to reset values. The next TRGn falling edge after RESn deasserts starts a clean transfer.

Optional Feature:
- Macro: FX_PAD_TURBO_EN.
- With the macro defined:
  - Extra input BTN_TURBO[1:0] (turbo enables for buttons I and II).
  - A phase flop, reset 0, toggles on every load event.
  - At load, word bit k (k=0,1) = BTN[k] & (~BTN_TURBO[k] | phase).
- Without the macro: no BTN_TURBO port, no phase flop; BTN is used directly.

Test Plan:
- Reset then idle: RESn=0 mid-cycle -> KP_SO=1, BUSY=0, BIT_CNT=0 immediately, with no CLK edge required.
- Full read: BTN=14'h0081, CONNECTED=1, TRGn pulse, 32 SCK pulses -> bits received LSB-first form 32'hF000_0081; BIT_CNT=32 then IDLE, KP_SO=1 after the final bit.
- Disconnected: CONNECTED=0, BTN=14'h3FFF, full read -> 32'h0000_0000.
- Timeout: TIMEOUT=16, read 5 bits, then stall SCK 20 CE cycles -> return to IDLE at the 16th stalled cycle, BUSY=0, BIT_CNT=0; a following full read returns the correct word.
- Restart and stability: TRGn falls after 10 bits -> BIT_CNT=0, new word loaded. Changing BTN to 14'h0000 after load, mid-transfer, still returns the originally latched 32'hF000_0081.
- FX_PAD_TURBO_EN: BTN=14'h0001, BTN_TURBO=2'b01, four consecutive reads -> bit0 reads 1,0,1,0 (phase toggles at each load; first load uses phase=1). Without the macro, all four read 1.
